// File: rtl/score_history_store_pkg.sv
// Shared types for the play-history ring buffer: record layout, FSM states, depth.
package score_history_store_pkg;

  localparam int HIST_DEPTH = 9;
  localparam int NAME_LEN   = 16;

  localparam logic [NAME_LEN*8-1:0] BLANK_NAME = {NAME_LEN{8'h20}};

  typedef struct packed {
    logic [7:0]            user_id;
    logic [15:0]           score;
    logic [NAME_LEN*8-1:0] name;
  } PlayRecord;

  typedef enum logic [1:0] {HS_IDLE, HS_COMMIT, HS_CLEAR} HistStoreState;

  localparam PlayRecord BLANK_REC = '{user_id: 8'd0, score: 16'd0, name: BLANK_NAME};

  // Ring-pointer increment that wraps at an arbitrary depth (no modulo hardware).
  function automatic logic [3:0] wrap_inc(input logic [3:0] v, input int depth);
    return (v == 4'(depth - 1)) ? 4'd0 : v + 4'd1;
  endfunction

endpackage

// File: rtl/score_history_store_hist_index_map.sv
// Maps a display index (1 = newest) onto a physical ring slot.
module hist_index_map
  import score_history_store_pkg::*;
#(
  parameter int DEPTH = HIST_DEPTH
) (
  input  logic [3:0] head,
  input  logic [3:0] count,
  input  logic [7:0] k,
  output logic [3:0] slot,
  output logic       valid
);

  logic [3:0] off;

  always_comb begin
    valid = (k != 8'd0) && (k <= {4'd0, count});
    // Only meaningful when valid, where k <= DEPTH fits in 4 bits.
    off   = k[3:0] - 4'd1;
    // Wrapping subtract; 4-bit overflow of head+DEPTH cancels in the subtraction.
    slot  = (head >= off) ? (head - off) : (head + 4'(DEPTH) - off);
  end

endmodule

// File: rtl/score_history_store.sv
// Newest-first ring store of finished plays with registered indexed reads,
// all-time best score, and a DEPTH-cycle slot-by-slot clear.
module score_history_store
  import score_history_store_pkg::*;
#(
  parameter int DEPTH = HIST_DEPTH
) (
  input  logic        prog_clk,
  input  logic        rst_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  PlayRecord   wr_record,
  input  logic        clr,
  input  logic [7:0]  read_record_id,
  output PlayRecord   record_data,
  output logic        rec_valid,
  output logic [3:0]  rec_count,
  output logic [15:0] best_score,
  output logic        busy
);

  HistStoreState state, state_nxt;
  logic          clr_pend;
  logic          clr_req;
  logic [3:0]    head;
  logic [3:0]    head_inc;
  logic [3:0]    clr_cnt;
  logic          clr_last;
  PlayRecord     wr_buf;
  PlayRecord     slots [DEPTH];
  logic [3:0]    map_slot;
  logic          map_valid;

  assign clr_req  = clr | clr_pend;
  assign head_inc = wrap_inc(head, DEPTH);
  assign clr_last = (clr_cnt == 4'(DEPTH - 1));

  always_comb begin
    state_nxt = state;
    wr_ready  = 1'b0;
    busy      = 1'b0;
    case (state)
      HS_IDLE: begin
        // A clear request wins over a simultaneous write offer.
        wr_ready = ~clr_req;
        if (clr_req)       state_nxt = HS_CLEAR;
        else if (wr_valid) state_nxt = HS_COMMIT;
      end
      HS_COMMIT: begin
        busy      = 1'b1;
        state_nxt = HS_IDLE;
      end
      HS_CLEAR: begin
        busy = 1'b1;
        if (clr_last) state_nxt = HS_IDLE;
      end
      default: state_nxt = HS_IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HS_IDLE;
      head       <= 4'(DEPTH - 1);
      rec_count  <= 4'd0;
      best_score <= 16'd0;
      clr_pend   <= 1'b0;
      clr_cnt    <= 4'd0;
      wr_buf     <= BLANK_REC;
    end else begin
      state <= state_nxt;
      if (wr_valid && wr_ready) wr_buf <= wr_record;

      case (state)
        HS_COMMIT: begin
          head <= head_inc;
          if (rec_count != 4'(DEPTH)) rec_count <= rec_count + 4'd1;
          if (wr_buf.score > best_score) best_score <= wr_buf.score;
        end
        HS_CLEAR: begin
          if (clr_cnt == 4'd0) begin
            rec_count  <= 4'd0;
            best_score <= 16'd0;
            head       <= 4'(DEPTH - 1);
          end
          clr_cnt <= clr_last ? 4'd0 : clr_cnt + 4'd1;
        end
        default: ;
      endcase

      // A fresh clr arriving in a non-IDLE cycle is remembered even on CLEAR entry.
      if (clr && state != HS_IDLE)                   clr_pend <= 1'b1;
      else if (state == HS_CLEAR && clr_cnt == 4'd0) clr_pend <= 1'b0;
    end
  end

  always_ff @(posedge prog_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) slots[i] <= BLANK_REC;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (state == HS_CLEAR && clr_cnt == 4'(i))
          slots[i] <= BLANK_REC;
        else if (state == HS_COMMIT && head_inc == 4'(i))
          slots[i] <= wr_buf;
      end
    end
  end

  hist_index_map #(.DEPTH(DEPTH)) u_map (
    .head  (head),
    .count (rec_count),
    .k     (read_record_id),
    .slot  (map_slot),
    .valid (map_valid)
  );

  always_ff @(posedge prog_clk or negedge rst_n) begin
    if (!rst_n) begin
      record_data <= BLANK_REC;
      rec_valid   <= 1'b0;
    end else if (state == HS_CLEAR || !map_valid) begin
      record_data <= BLANK_REC;
      rec_valid   <= 1'b0;
    end else begin
      record_data <= slots[map_slot];
      rec_valid   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_score_history_store.sv
// Directed bench for score_history_store: reset, write, wrap, best score, clear paths.
module tb_score_history_store;
  import score_history_store_pkg::*;

  logic        prog_clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  PlayRecord   wr_record;
  logic        clr;
  logic [7:0]  read_record_id;
  PlayRecord   record_data;
  logic        rec_valid;
  logic [3:0]  rec_count;
  logic [15:0] best_score;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;

  PlayRecord blank_exp;
  PlayRecord r_obs;
  logic      v_obs;

  always #5 prog_clk = ~prog_clk;

  score_history_store dut (
    .prog_clk       (prog_clk),
    .rst_n          (rst_n),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_record      (wr_record),
    .clr            (clr),
    .read_record_id (read_record_id),
    .record_data    (record_data),
    .rec_valid      (rec_valid),
    .rec_count      (rec_count),
    .best_score     (best_score),
    .busy           (busy)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic PlayRecord mk(input logic [7:0] u, input logic [15:0] s, input logic [127:0] n);
    PlayRecord r;
    r.user_id = u;
    r.score   = s;
    r.name    = n;
    return r;
  endfunction

  task automatic tick;
    @(posedge prog_clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; wr_valid = 1'b0; clr = 1'b0; read_record_id = 8'd0; wr_record = '0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic rd(input logic [7:0] k, output PlayRecord r, output logic v);
    read_record_id = k;
    tick;
    r = record_data;
    v = rec_valid;
  endtask

  task automatic write_rec(input string tag, input PlayRecord r);
    int n;
    wr_record = r;
    wr_valid  = 1'b1;
    #1;
    n = 0;
    while (!wr_ready && n < 20) begin tick; n++; end
    chk({tag, "_ready"}, wr_ready, 1'b1);
    tick;
    wr_valid = 1'b0;
    chk({tag, "_commit_ready"}, wr_ready, 1'b0);
    chk({tag, "_commit_busy"}, busy, 1'b1);
    tick;
    chk({tag, "_after_ready"}, wr_ready, 1'b1);
  endtask

  initial begin
    int zc;
    int guard;
    blank_exp = mk(8'd0, 16'd0, {16{8'h20}});

    // Reset state and empty reads
    do_reset;
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", rec_count, 4'd0);
    chk("rst_best", best_score, 16'd0);
    chk("rst_rec_valid", rec_valid, 1'b0);
    chk("rst_data", record_data, blank_exp);
    rd(8'd1, r_obs, v_obs); chk("rst_rd1_v", v_obs, 1'b0); chk("rst_rd1_d", r_obs, blank_exp);
    rd(8'd0, r_obs, v_obs); chk("rst_rd0_v", v_obs, 1'b0); chk("rst_rd0_d", r_obs, blank_exp);
    rd(8'd9, r_obs, v_obs); chk("rst_rd9_v", v_obs, 1'b0); chk("rst_rd9_d", r_obs, blank_exp);

    // Single write
    write_rec("single", mk(8'd3, 16'd4487, "Tiny Stars      "));
    chk("single_count", rec_count, 4'd1);
    chk("single_best", best_score, 16'd4487);
    rd(8'd1, r_obs, v_obs);
    chk("single_rd1_v", v_obs, 1'b1);
    chk("single_rd1_d", r_obs, mk(8'd3, 16'd4487, "Tiny Stars      "));
    rd(8'd2, r_obs, v_obs);
    chk("single_rd2_v", v_obs, 1'b0);
    chk("single_rd2_d", r_obs, blank_exp);
    rd(8'd200, r_obs, v_obs);
    chk("single_rd200_v", v_obs, 1'b0);

    // Wrap-around with wr_valid held high
    do_reset;
    wr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_record = mk(8'(i), 16'(10 + i), "Wrap Test Song  ");
      #1;
      chk("wrap_idle_ready", wr_ready, 1'b1);
      tick;
      chk("wrap_commit_ready", wr_ready, 1'b0);
      tick;
    end
    wr_valid = 1'b0;
    chk("wrap_count", rec_count, 4'd9);
    chk("wrap_best", best_score, 16'd19);
    for (int k = 1; k <= 9; k++) begin
      rd(8'(k), r_obs, v_obs);
      chk("wrap_rd_v", v_obs, 1'b1);
      chk("wrap_rd_d", r_obs, mk(8'(10 - k), 16'(20 - k), "Wrap Test Song  "));
    end

    // Overwriting the best record does not lower best_score
    write_rec("best500", mk(8'd1, 16'd500, "Big Score       "));
    for (int i = 0; i < 9; i++) write_rec("w100", mk(8'd2, 16'd100, "Small Score     "));
    chk("best_kept", best_score, 16'd500);
    chk("best_count", rec_count, 4'd9);
    for (int k = 1; k <= 9; k++) begin
      rd(8'(k), r_obs, v_obs);
      chk("best_rd_score", r_obs.score, 16'd100);
    end

    // Clear and write in the same IDLE cycle
    wr_record = mk(8'd7, 16'd777, "After Clear     ");
    wr_valid = 1'b1;
    clr = 1'b1;
    read_record_id = 8'd1;
    #1;
    chk("clrw_ready_c", wr_ready, 1'b0);
    tick;
    clr = 1'b0;
    #1;
    chk("clrw_busy_c1", busy, 1'b1);
    chk("clrw_ready_c1", wr_ready, 1'b0);
    tick;
    chk("clrw_count_c2", rec_count, 4'd0);
    chk("clrw_best_c2", best_score, 16'd0);
    chk("clrw_rd_in_clear", rec_valid, 1'b0);
    zc = 2;
    guard = 0;
    while (guard < 30) begin
      tick;
      guard++;
      if (wr_ready) break;
      zc++;
    end
    chk("clrw_len", zc, 9);
    chk("clrw_count_end", rec_count, 4'd0);
    tick;
    wr_valid = 1'b0;
    chk("clrw_commit_ready", wr_ready, 1'b0);
    tick;
    chk("clrw_count_after", rec_count, 4'd1);
    chk("clrw_best_after", best_score, 16'd777);
    rd(8'd1, r_obs, v_obs);
    chk("clrw_rd1_v", v_obs, 1'b1);
    chk("clrw_rd1_d", r_obs, mk(8'd7, 16'd777, "After Clear     "));

    // clr during COMMIT, then reset in the middle of CLEAR
    wr_record = mk(8'd8, 16'd55, "Pending Clear   ");
    wr_valid = 1'b1;
    tick;
    wr_valid = 1'b0;
    clr = 1'b1;
    chk("pend_commit_busy", busy, 1'b1);
    tick;
    clr = 1'b0;
    #1;
    chk("pend_idle_ready", wr_ready, 1'b0);
    chk("pend_idle_busy", busy, 1'b0);
    chk("pend_idle_count", rec_count, 4'd2);
    chk("pend_idle_best", best_score, 16'd777);
    tick;
    chk("pend_clear_busy", busy, 1'b1);
    tick;
    chk("pend_clear_count", rec_count, 4'd0);
    wr_record = mk(8'd9, 16'd999, "Discarded       ");
    wr_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_ready", wr_ready, 1'b1);
    chk("mrst_count", rec_count, 4'd0);
    chk("mrst_best", best_score, 16'd0);
    chk("mrst_rec_valid", rec_valid, 1'b0);
    chk("mrst_data", record_data, blank_exp);
    wr_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;
    rd(8'd1, r_obs, v_obs);
    chk("mrst_rd1_v", v_obs, 1'b0);
    chk("mrst_rd1_d", r_obs, blank_exp);
    chk("mrst_count_after", rec_count, 4'd0);
    chk("mrst_best_after", best_score, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
